adc_serial_reader: RTL
======================

Name: adc_serial_reader

Overview:
- Serial-ADC front end that sits directly upstream of the 74HC595 shift-register driver in the ADC display path.
- Frames one conversion on the ADC's serial interface using CS_n, SCLK and MISO, then extracts the DATA_BITS sample.
- Holds the sample on a parallel bus that the shift-register driver reloads on every pass, and issues a one-cycle valid pulse per new sample.
- Free-runs while en is high.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period, and the CS_n-to-first-SCLK-fall setup time; must be >= 1.
- FRAME_BITS, 16: SCLK rising edges per conversion frame.
- LEAD_BITS, 3: leading bits in the frame that must read as zero, sent before the sample MSB.
- DATA_BITS, 8: sample width; LEAD_BITS+DATA_BITS <= FRAME_BITS.
- QUIET_CYCLES, 4: clk cycles CS_n is held high after a frame, before the next frame may start; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  high = run conversions back-to-back; sampled only in IDLE.
- MISO  in  1  ADC serial data; changes after SCLK falls.
- CS_n  out  1  ADC chip select, active low.
- SCLK  out  1  ADC serial clock; idles high.
- data  out  DATA_BITS  last completed sample; held until the next valid.
- valid  out  1  one-cycle pulse when data updates.
- frame_err  out  1  updated with data; 1 when any leading bit of that frame read 1.
- busy  out  1  high from frame start through the end of QUIET.

Behaviour:
- Reset (rst=1 at a clk edge):
  - CS_n=1, SCLK=1, data=0, valid=0, frame_err=0, busy=0.
  - Shift register and counters cleared; state=IDLE.
  - Takes effect from any state; a partial frame is discarded and valid does not pulse.
- All outputs are registered.
- States are IDLE, SETUP, SHIFT, DONE, QUIET.
- IDLE:
  - en=1 → CS_n<=0, busy<=1, div_cnt<=0, bit_cnt<=0, go to SETUP.
  - en=0 → stay in IDLE.
- SETUP: count CLK_DIV cycles; on the last one, SCLK<=0 (first falling edge) and go to SHIFT.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1; at terminal count, toggle SCLK and reset div_cnt.
  - On each toggle 0→1, the same clk edge captures MISO: sreg<={sreg[FRAME_BITS-2:0],MISO}, bit_cnt++.
  - On the FRAME_BITS-th rising toggle, capture the final bit, leave SCLK=1 and go to DONE.
- DONE (one cycle):
  - CS_n<=1.
  - data<=sreg[FRAME_BITS-1-LEAD_BITS -: DATA_BITS]; the first received bit is the frame MSB.
  - frame_err<=|sreg[FRAME_BITS-1 -: LEAD_BITS] (0 when LEAD_BITS=0).
  - valid<=1; go to QUIET.
- QUIET: valid<=0; count QUIET_CYCLES cycles; on the last one, busy<=0 and go to IDLE.
- Latency:
  - CS_n falls on the edge where en is sampled in IDLE.
  - valid is high CLK_DIV*2*FRAME_BITS+1 cycles later (65 at defaults).
  - Back-to-back CS_n high time is QUIET_CYCLES+1 cycles.
- en is ignored outside IDLE: dropping en mid-frame completes the frame and its valid; a one-cycle en in IDLE yields exactly one frame.
- SCLK stays high outside SETUP/SHIFT; no glitches.
- Exactly FRAME_BITS rising edges occur per frame.
- data and frame_err change only in DONE or on reset.

Test Plan:
- Reset: rst=1 for 3 cycles → CS_n=1, SCLK=1, data=0x00, valid=0, frame_err=0, busy=0.
- Single frame at defaults, en pulsed 1 cycle, ADC model sends 0x14A0 MSB-first → 16 SCLK rises, valid pulses once 65 cycles after CS_n falls, data=0xA5, frame_err=0, no second frame.
- Frame 0x94A0 → data=0xA5, frame_err=1.
- en held high with alternating frames 0x0FE0/0x0020 → data alternates 0x7F/0x01, CS_n high exactly 5 cycles between frames, one valid per frame.
- en deasserted after the 5th SCLK rise → frame completes with valid; the design then returns to IDLE and CS_n stays high.
- rst asserted after the 10th SCLK rise → next cycle CS_n=1, SCLK=1, data=0, no valid; a following en frame with 0x14A0 gives data=0xA5.

Source files
------------

// File: rtl/adc_serial_reader.sv
// adc_serial_reader: frames one conversion on a serial ADC (CS_n/SCLK/MISO),
// extracts the DATA_BITS sample that follows LEAD_BITS zero bits, and holds it
// on a parallel bus with a one-cycle valid pulse per new sample.
module adc_serial_reader #(
    parameter int CLK_DIV      = 2,
    parameter int FRAME_BITS   = 16,
    parameter int LEAD_BITS    = 3,
    parameter int DATA_BITS    = 8,
    parameter int QUIET_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 MISO,
    output logic                 CS_n,
    output logic                 SCLK,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    // Counter widths; a width of at least 1 keeps CLK_DIV=1 / QUIET_CYCLES=1 legal.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int Q_W   = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        QUIET
    } state_t;

    state_t                state_q;
    logic [DIV_W-1:0]      div_cnt_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [Q_W-1:0]        quiet_cnt_q;
    logic [FRAME_BITS-1:0] sreg_q;
    logic [FRAME_BITS-1:0] sreg_d;
    logic                  div_last;
    logic                  quiet_last;
    logic                  bit_last;
    logic                  lead_err;

    // Next shift-register value and terminal-count decodes.
    always_comb begin
        sreg_d     = {sreg_q[FRAME_BITS-2:0], MISO};
        div_last   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        quiet_last = (quiet_cnt_q == Q_W'(QUIET_CYCLES - 1));
        bit_last   = (bit_cnt_q == BIT_W'(FRAME_BITS - 1));
    end

    // Leading-bit check; with no leading bits a frame can never be flagged.
    if (LEAD_BITS > 0) begin : g_lead
        assign lead_err = |sreg_q[FRAME_BITS-1 -: LEAD_BITS];
    end else begin : g_no_lead
        assign lead_err = 1'b0;
    end

    // Frame sequencer: drives CS_n/SCLK, shifts in MISO on each SCLK rise and
    // publishes the sample; every output is a register of this block.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is cleared with the rest of the state so a
            // frame aborted by reset leaves nothing behind for the next one.
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            sreg_q      <= '0;
            CS_n        <= 1'b1;
            SCLK        <= 1'b1;
            data        <= '0;
            valid       <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge values (e.g. SCLK below is the level before this toggle).
            valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        CS_n      <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        SCLK      <= 1'b0;
                        div_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        SCLK      <= ~SCLK;
                        if (!SCLK) begin
                            // Rising toggle: capture MISO on the same edge.
                            sreg_q    <= sreg_d;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_last) begin
                                state_q <= DONE;
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    CS_n        <= 1'b1;
                    data        <= sreg_q[FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
                    frame_err   <= lead_err;
                    valid       <= 1'b1;
                    quiet_cnt_q <= '0;
                    state_q     <= QUIET;
                end
                QUIET: begin
                    if (quiet_last) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        quiet_cnt_q <= quiet_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
